// File: rtl/issue_scheduler_pkg.sv
// Shared types and sizing for the issue scheduler: reservation-station row,
// functional-unit ids and the wakeup-match helper used on stored and bypassed rows.
package issue_scheduler_pkg;

   localparam int RS_DEPTH = 16;
   localparam int N_ALLOC  = 2;
   localparam int N_FU     = 3;
   localparam int N_WAKE   = 3;
   localparam int PREG_W   = 6;
   localparam int ROB_W    = 5;
   localparam int OPND_W   = 16;
   localparam int IDX_W    = $clog2(RS_DEPTH);
   localparam int CNT_W    = $clog2(RS_DEPTH) + 1;

   typedef logic [PREG_W-1:0] p_reg;

   typedef enum logic [1:0] {
      FU_ALU0 = 2'd0,
      FU_ALU1 = 2'd1,
      FU_MEM  = 2'd2
   } fu_id_e;

   typedef struct packed {
      fu_id_e             fu_id;
      p_reg               src1;
      logic               src1_rdy;
      p_reg               src2;
      logic               src2_rdy;
      p_reg               dst;
      logic [ROB_W-1:0]   rob_idx;
      logic [OPND_W-1:0]  imm;
   } rs_row_struct;

   // Tag 0 is the hardwired-ready register.
   function automatic logic src_ready(input p_reg tag, input logic rdy,
                                      input logic [0:N_WAKE-1] wake_valid,
                                      input p_reg wake_preg [N_WAKE]);
      logic hit;
      hit = rdy || (tag == '0);
      for (int w = 0; w < N_WAKE; w++)
         if (wake_valid[w] && (wake_preg[w] == tag)) hit = 1'b1;
      return hit;
   endfunction

endpackage

// File: rtl/issue_scheduler_age.sv
// Age matrix for the reservation station: tracks pairwise older-than relations and
// returns the oldest requester (one-hot) for each request vector.
module rs_age_matrix
   import issue_scheduler_pkg::*;
#(
   parameter int N_REQ = N_FU
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_flush,
   input  logic [0:N_ALLOC-1]    i_alloc_en,
   input  logic [IDX_W-1:0]      i_alloc_idx [N_ALLOC],
   input  logic [RS_DEPTH-1:0]   i_free_vec,
   input  logic [RS_DEPTH-1:0]   i_req [N_REQ],
   output logic [RS_DEPTH-1:0]   o_oldest [N_REQ]
);

   // older_q[j][i] set means entry j is older than entry i
   logic [RS_DEPTH-1:0] older_q [RS_DEPTH];
   logic [RS_DEPTH-1:0] older_d [RS_DEPTH];
   logic [RS_DEPTH-1:0] older_than [RS_DEPTH];

   // Frees first, then allocations in slot order so a same-edge realloc wins
   // and slot 1 lands younger than slot 0.
   always_comb begin
      older_d = older_q;
      for (int e = 0; e < RS_DEPTH; e++) begin
         if (i_free_vec[e]) begin
            older_d[e] = '0;
            for (int j = 0; j < RS_DEPTH; j++) older_d[j][e] = 1'b0;
         end
      end
      for (int s = 0; s < N_ALLOC; s++) begin
         if (i_alloc_en[s]) begin
            older_d[i_alloc_idx[s]] = '0;
            for (int j = 0; j < RS_DEPTH; j++)
               older_d[j][i_alloc_idx[s]] = (j != int'(i_alloc_idx[s]));
         end
      end
   end

   always_comb begin
      for (int i = 0; i < RS_DEPTH; i++) begin
         older_than[i] = '0;
         for (int j = 0; j < RS_DEPTH; j++) older_than[i][j] = older_q[j][i];
      end
   end

   always_comb begin
      for (int r = 0; r < N_REQ; r++) begin
         o_oldest[r] = '0;
         for (int i = 0; i < RS_DEPTH; i++)
            o_oldest[r][i] = i_req[r][i] && !(|(i_req[r] & older_than[i]));
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         older_q <= '{default: '0};
      end else if (i_flush) begin
         older_q <= '{default: '0};
      end else begin
         older_q <= older_d;
      end
   end

endmodule

// File: rtl/issue_scheduler.sv
// Reservation-station issue scheduler: holds renamed rows, wakes sources from
// completion broadcasts and issues the oldest ready row per free functional unit.
module issue_scheduler
   import issue_scheduler_pkg::*;
#(
   parameter bit ALLOC_OVF_CHECK = 1'b1
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_flush,
   input  logic [0:N_ALLOC-1] i_alloc_valid,
   input  rs_row_struct       i_alloc_row [N_ALLOC],
   output logic               o_alloc_ready,
   output logic [CNT_W-1:0]   o_free_count,
   input  logic [0:N_WAKE-1]  i_wake_valid,
   input  p_reg               i_wake_preg [N_WAKE],
   input  logic [0:N_FU-1]    i_fu_ready,
   output logic [0:N_FU-1]    o_issue_valid,
   output rs_row_struct       o_issue_inst [N_FU]
);

   logic [RS_DEPTH-1:0] valid_q, valid_d;
   rs_row_struct        row_q [RS_DEPTH];
   rs_row_struct        row_d [RS_DEPTH];
   logic [0:N_FU-1]     issue_valid_q, issue_valid_d;
   rs_row_struct        issue_inst_q [N_FU];
   rs_row_struct        issue_inst_d [N_FU];
   logic [CNT_W-1:0]    free_count_q, free_count_d;
   logic                alloc_ready_q, alloc_ready_d;

   logic [RS_DEPTH-1:0] req [N_FU];
   logic [RS_DEPTH-1:0] gnt [N_FU];
   logic [RS_DEPTH-1:0] issued;
   logic [0:N_ALLOC-1]  alloc_en;
   logic [IDX_W-1:0]    alloc_idx [N_ALLOC];

   always_comb begin
      for (int k = 0; k < N_FU; k++) begin
         req[k] = '0;
         for (int i = 0; i < RS_DEPTH; i++)
            req[k][i] = valid_q[i] && i_fu_ready[k] && (int'(row_q[i].fu_id) == k)
                        && row_q[i].src1_rdy && row_q[i].src2_rdy;
      end
   end

   rs_age_matrix #(.N_REQ(N_FU)) u_age (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_flush     (i_flush),
      .i_alloc_en  (alloc_en),
      .i_alloc_idx (alloc_idx),
      .i_free_vec  (issued),
      .i_req       (req),
      .o_oldest    (gnt)
   );

   // Entries issuing on this edge are already reusable by this edge's allocation.
   always_comb begin
      logic [RS_DEPTH-1:0] avail;
      issued = '0;
      for (int k = 0; k < N_FU; k++) issued = issued | gnt[k];
      avail = ~valid_q | issued;
      for (int s = 0; s < N_ALLOC; s++) begin
         alloc_en[s]  = i_alloc_valid[s] && alloc_ready_q && !i_flush;
         alloc_idx[s] = '0;
         if (alloc_en[s]) begin
            for (int i = RS_DEPTH-1; i >= 0; i--)
               if (avail[i]) alloc_idx[s] = IDX_W'(i);
            avail[alloc_idx[s]] = 1'b0;
         end
      end
   end

   always_comb begin
      valid_d = valid_q & ~issued;
      row_d   = row_q;
      for (int i = 0; i < RS_DEPTH; i++) begin
         row_d[i].src1_rdy = src_ready(row_q[i].src1, row_q[i].src1_rdy, i_wake_valid, i_wake_preg);
         row_d[i].src2_rdy = src_ready(row_q[i].src2, row_q[i].src2_rdy, i_wake_valid, i_wake_preg);
      end
      for (int s = 0; s < N_ALLOC; s++) begin
         if (alloc_en[s]) begin
            row_d[alloc_idx[s]] = i_alloc_row[s];
            row_d[alloc_idx[s]].src1_rdy = src_ready(i_alloc_row[s].src1, i_alloc_row[s].src1_rdy,
                                                     i_wake_valid, i_wake_preg);
            row_d[alloc_idx[s]].src2_rdy = src_ready(i_alloc_row[s].src2, i_alloc_row[s].src2_rdy,
                                                     i_wake_valid, i_wake_preg);
            valid_d[alloc_idx[s]] = 1'b1;
         end
      end
      if (i_flush) valid_d = '0;

      for (int k = 0; k < N_FU; k++) begin
         issue_valid_d[k] = (|gnt[k]) && !i_flush;
         issue_inst_d[k]  = issue_inst_q[k];
         for (int i = 0; i < RS_DEPTH; i++) begin
            if (gnt[k][i] && !i_flush) begin
               issue_inst_d[k] = row_q[i];
               issue_inst_d[k].src1_rdy = 1'b1;
               issue_inst_d[k].src2_rdy = 1'b1;
            end
         end
      end

      free_count_d = '0;
      for (int i = 0; i < RS_DEPTH; i++) free_count_d = free_count_d + CNT_W'(!valid_d[i]);
      alloc_ready_d = (free_count_d >= CNT_W'(N_ALLOC));
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         valid_q       <= '0;
         row_q         <= '{default: '0};
         issue_valid_q <= '0;
         issue_inst_q  <= '{default: '0};
         free_count_q  <= CNT_W'(RS_DEPTH);
         alloc_ready_q <= 1'b1;
      end else begin
         valid_q       <= valid_d;
         row_q         <= row_d;
         issue_valid_q <= issue_valid_d;
         issue_inst_q  <= issue_inst_d;
         free_count_q  <= free_count_d;
         alloc_ready_q <= alloc_ready_d;
      end
   end

   assign o_issue_valid = issue_valid_q;
   assign o_issue_inst  = issue_inst_q;
   assign o_free_count  = free_count_q;
   assign o_alloc_ready = alloc_ready_q;

   if (ALLOC_OVF_CHECK) begin : g_ovf_chk
      a_alloc_when_full: assert property (@(posedge i_clk) disable iff (i_rst)
                                          (|i_alloc_valid) |-> alloc_ready_q)
         else $error("allocate request dropped while o_alloc_ready=0");
   end

endmodule
